// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: command and response valid/ready bundle between host and issuer
interface alu_cmd_issuer_if #(
    parameter int DATA_W = 8,
    parameter int OP_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic              cmd_use_acc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero;
    logic              rsp_illegal;
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_illegal
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_illegal
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: registered ALU command front-end with accumulator; ALU_CMD_STATS_EN adds op/illegal counters
module alu_cmd_issuer #(
    parameter int DATA_W = 8,
    parameter int OP_W = 3,
    parameter logic [DATA_W-1:0] ACC_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_cmd_issuer_if.slave   bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] acc,
    output logic              busy
`ifdef ALU_CMD_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_ops,
    output logic [7:0]        stat_illegal
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, state_d;
    logic   illegal;
    logic   rsp_hs;
    always_comb begin
        state_d = state;
        state_d = state == IDLE  ? (bus.cmd_valid ? ISSUE : IDLE) :
                  state == ISSUE ? RESP :
                  (bus.rsp_ready ? IDLE : RESP);
        bus.cmd_ready = state == IDLE;
        bus.rsp_valid = state == RESP;
        busy          = state != IDLE;
        rsp_hs        = state == RESP && bus.rsp_ready;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a           <= '0;
            alu_b           <= '0;
            alu_opcode      <= '0;
            illegal         <= 1'b0;
            bus.rsp_data    <= '0;
            bus.rsp_zero    <= 1'b0;
            bus.rsp_illegal <= 1'b0;
            acc             <= ACC_INIT;
        end else begin
            if (state == IDLE && bus.cmd_valid) begin
                alu_a      <= bus.cmd_use_acc ? acc : bus.cmd_a;
                alu_b      <= bus.cmd_b;
                alu_opcode <= bus.cmd_op;
                illegal    <= bus.cmd_op > OP_W'(4);
            end
            // ALU has had the full ISSUE cycle to settle on the registered operands
            if (state == ISSUE) begin
                bus.rsp_data    <= alu_result;
                bus.rsp_zero    <= alu_result == '0;
                bus.rsp_illegal <= illegal;
                if (!illegal) acc <= alu_result;
            end
        end
    end
`ifdef ALU_CMD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops     <= '0;
            stat_illegal <= '0;
        end else if (stat_clr) begin
            stat_ops     <= '0;
            stat_illegal <= '0;
        end else if (rsp_hs) begin
            stat_ops <= stat_ops + 16'd1;
            if (bus.rsp_illegal && stat_illegal != 8'hFF) stat_illegal <= stat_illegal + 8'd1;
        end
    end
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
`endif
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Sequential command front-end that drives the team's 8-bit combinational ALU (operands A/B, 3-bit opcode, 8-bit result).
- Accepts operation commands over a valid/ready interface.
- Presents registered operands and opcode to the ALU, then captures the ALU result one cycle later.
- Returns the result plus status flags over a valid/ready response interface.
- Keeps an accumulator so commands can be chained without the host re-supplying operand A.

Parameters:
DATA_W, 8, operand/result width; must equal ALU width.
OP_W, 3, opcode width; must equal ALU opcode width.
ACC_INIT, 8'h00, accumulator value after reset.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  issuer can accept a command.
cmd_op  input  OP_W  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 not-A; 101..111 illegal.
cmd_a  input  DATA_W  operand A; ignored when cmd_use_acc=1.
cmd_b  input  DATA_W  operand B.
cmd_use_acc  input  1  substitute the accumulator for operand A.
alu_a  output  DATA_W  to ALU input A (registered).
alu_b  output  DATA_W  to ALU input B (registered).
alu_opcode  output  OP_W  to ALU opcode (registered).
alu_result  input  DATA_W  from ALU result.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_data  output  DATA_W  captured result.
rsp_zero  output  1  rsp_data == 0.
rsp_illegal  output  1  command opcode was 101..111.
acc  output  DATA_W  current accumulator value.
busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low; all state clears immediately on assertion.
- Reset values: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_illegal=0, alu_a=0, alu_b=0, alu_opcode=0, acc=ACC_INIT, busy=0.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: cmd_ready=1. On the edge where cmd_valid & cmd_ready:
    - alu_a <= (cmd_use_acc ? acc : cmd_a); alu_b <= cmd_b; alu_opcode <= cmd_op.
    - Latch illegal = (cmd_op > 3'b100).
    - Go to ISSUE.
  - ISSUE: exactly one cycle; cmd_ready=0; alu_* held stable so the combinational ALU settles. On the next edge:
    - rsp_data <= alu_result; rsp_zero <= (alu_result == 0); rsp_illegal <= latched illegal.
    - If not illegal, acc <= alu_result; if illegal, acc is unchanged.
    - Go to RESP.
  - RESP: rsp_valid=1, cmd_ready=0. rsp_data, rsp_zero and rsp_illegal are held stable while rsp_ready=0. On the edge with rsp_ready=1, rsp_valid clears and the FSM returns to IDLE.
- Latency and throughput:
  - rsp_valid rises on the first edge after ISSUE, i.e. 2 edges after the command handshake.
  - Minimum command spacing is 3 cycles. No new command is accepted in the cycle the response completes.
- Arithmetic: results are truncated to DATA_W; add and sub wrap modulo 2^DATA_W. The issuer does no arithmetic itself and trusts alu_result.
- Operand handling: for opcode 100 (not-A), alu_b is still driven from cmd_b and the ALU ignores it.
- Illegal opcodes: passed through to the ALU, which returns 0. Response is rsp_data=0, rsp_zero=1, rsp_illegal=1.
- Protocol rules:
  - cmd_valid while not ready is ignored; the host must hold the command until the handshake.
  - rsp_valid never drops without the handshake.
- busy = (state != IDLE); it is the inverse of cmd_ready.
- Reset mid-operation: a pending command or response is discarded. acc returns to ACC_INIT and outputs return to their reset values immediately.

Optional Feature:
Macro ALU_CMD_STATS_EN.
- Defined:
  - Adds output stat_ops[15:0], which counts each completed response handshake and wraps at 16'hFFFF.
  - Adds output stat_illegal[7:0], which counts responses with rsp_illegal=1 and saturates at 8'hFF.
  - Adds input stat_clr; when high, both counters clear on that edge, taking priority over a same-cycle increment.
  - All three are reset to 0 by rst_n.
- Undefined: the three ports and both counters are absent. All other behaviour is identical.

Test Plan:
- Add: cmd_op=000, a=8'h7F, b=8'h01, use_acc=0 -> rsp_valid 2 edges after handshake; rsp_data=8'h80, rsp_zero=0, rsp_illegal=0, acc=8'h80.
- Wrap: add a=8'hFF, b=8'h01 -> rsp_data=8'h00, rsp_zero=1. Then sub a=8'h00, b=8'h01 -> rsp_data=8'hFF, rsp_zero=0.
- Accumulator chain: add 3+4 -> acc=8'h07. Next, or with use_acc=1, cmd_a=8'hAA (ignored), b=8'h08 -> alu_a=8'h07, rsp_data=8'h0F, acc=8'h0F.
- Illegal opcode: op=110, a=8'h12, b=8'h34, starting with acc=8'h0F -> rsp_data=8'h00, rsp_zero=1, rsp_illegal=1, acc stays 8'h0F. With ALU_CMD_STATS_EN: stat_illegal increments by 1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP while cmd_valid=1 -> rsp_valid stays high, rsp_data stable, cmd_ready=0, no second command accepted. With rsp_ready=1, the handshake completes and cmd_ready=1 on the next cycle.
- Reset mid-RESP: assert rst_n=0 asynchronously between edges -> rsp_valid=0 and acc=ACC_INIT without waiting for a clock. After release, cmd_ready=1 and busy=0.
